detect_scheduler: RTL
=====================

# detect_scheduler

Round-robin controller that shares one serial 3-bit pattern-detection engine between two requesters. Each requester offers a WIDTH-bit word. The block grants one requester and latches its word and the configured pattern. It then streams the word MSB-first through an overlapping 3-bit matcher, one bit per cycle, and reports the match count and a per-bit match map to the granted requester. It sits between the word-level producers and the bit-serial detection logic, so neither producer drives the detector directly.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 3..15.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- req  in  2  request per channel; bit 0 = ch0, bit 1 = ch1
- data0  in  WIDTH  ch0 word; sampled only in the grant cycle
- data1  in  WIDTH  ch1 word; sampled only in the grant cycle
- cfg_pattern  in  3  pattern; bit 2 = oldest bit; sampled in the grant cycle
- gnt  out  2  one-hot, one-cycle pulse marking the accepted channel
- busy  out  1  high in SHIFT and REPORT
- done  out  1  one-cycle result pulse
- done_id  out  1  channel the current result belongs to
- match_cnt  out  4  number of matches in the word (0..WIDTH-2)
- match_map  out  WIDTH  bit i set when a match completes at word bit i

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- **IDLE:**
  - If req==00, stay in IDLE.
  - Otherwise select a winner. If only one bit is set, that channel wins. If both are set, the channel other than last_id wins.
  - In that cycle: pulse gnt for the winner; latch its data, cfg_pattern and id; clear the history, the count accumulator and the map accumulator; load bit index WIDTH-1; go to SHIFT.
- **SHIFT:**
  - Each cycle consume bit b = word[idx].
  - Match condition: at least 2 bits already consumed and {h1,h0,b}==pattern. On a match, increment the count and set map[idx].
  - Shift history: h1<=h0, h0<=b. Decrement idx.
  - Matches may overlap.
  - After idx==0 is consumed, go to REPORT.
- **REPORT:**
  - Drive done=1.
  - Load match_cnt, match_map and done_id from the accumulators.
  - Set last_id to the served id. Return to IDLE.
- match_map bits WIDTH-1 and WIDTH-2 are always 0.
- History does not carry across words.
- No abort: changes to req, data or cfg_pattern during SHIFT/REPORT have no effect. A dropped req that was already granted is still served.
- match_cnt, match_map and done_id are registered. They hold their value from one done to the next.
- **Reset** takes effect at the next edge from any state, including mid-word:
  - State returns to IDLE; no done is issued for the aborted word.
  - gnt=00, busy=0, done=0, done_id=0, match_cnt=0, match_map=0.
  - last_id=1, so ch0 wins the first tie.

## Timing
- Grant at cycle T, the IDLE cycle in which req is seen. gnt is combinational from IDLE and req.
- Bits consumed in cycles T+1..T+WIDTH; busy=1 in cycles T+1..T+WIDTH+1.
- done is high in cycle T+WIDTH+1. Results are visible from cycle T+WIDTH+2 onward, and done_id is valid with the same timing.
- Earliest next grant is cycle T+WIDTH+2, so the back-to-back grant period is WIDTH+2 cycles.
- A requester must keep req high until it sees its gnt bit. It must deassert req, or present a new word, in the cycle after gnt.

## Test plan
- **Reset then tie:** assert reset for 2 cycles, then req=11 → all outputs 0 during and after reset; first gnt=01.
- **Alternating word:** cfg_pattern=101, data0=8'b10101010, req=01 → gnt=01 at T; done at T+9; match_cnt=3, match_map=8'b00101010, done_id=0.
- **Overlap:** cfg_pattern=111, data1=8'hFF, req=10 → match_cnt=6, match_map=8'b00111111, done_id=1.
- **No match:** cfg_pattern=000, data0=8'hFF → done still pulses; match_cnt=0, match_map=0.
- **Fairness:** req=11 held continuously → gnt sequence 01,10,01,10 spaced 10 cycles apart; done_id sequence 0,1,0,1.
- **Reset mid-word:** reset asserted on the 4th SHIFT cycle, then req=10 → no done for the aborted word; busy=0 and results 0 after the edge; ch1 granted in the next IDLE cycle.

Source files
------------

// File: rtl/detect_scheduler_if.sv
// Requester-facing bus of the shared pattern-detection scheduler.
interface detect_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [2:0]       cfg_pattern;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] match_map;

    modport master (
        output req, data0, data1, cfg_pattern,
        input  gnt, busy, done, done_id, match_cnt, match_map
    );

    modport slave (
        input  req, data0, data1, cfg_pattern,
        output gnt, busy, done, done_id, match_cnt, match_map
    );
endinterface

// File: rtl/detect_scheduler.sv
// Round-robin arbiter feeding one bit-serial overlapping 3-bit pattern matcher;
// the granted word is streamed MSB-first and results return to its requester.
module detect_scheduler #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              reset,
    detect_scheduler_if.slave bus
);
    localparam int unsigned       IDX_W         = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  IDX_TOP       = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_FIRST_HIT = IDX_W'(WIDTH - 3);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [2:0]       pat_q;
    logic             id_q;
    logic             last_id_q;
    logic [1:0]       hist_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       acc_cnt_q;
    logic [WIDTH-1:0] acc_map_q;
    logic             done_id_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] map_q;

    logic       win_d;
    logic [1:0] gnt_d;
    logic       bit_d;
    logic       hit_d;
    logic [1:0] hist_d;

    always_comb begin
        win_d = 1'b0;
        if (bus.req == 2'b01)      win_d = 1'b0;
        else if (bus.req == 2'b10) win_d = 1'b1;
        else                       win_d = ~last_id_q;

        // Grant is suppressed while reset is held, since the edge will not honour it.
        gnt_d = 2'b00;
        if (!reset && state_q == IDLE && bus.req != 2'b00)
            gnt_d = win_d ? 2'b10 : 2'b01;

        // A window is complete only once two earlier bits of this word are in history.
        bit_d  = word_q[idx_q];
        hit_d  = (idx_q <= IDX_FIRST_HIT) && ({hist_q, bit_d} == pat_q);
        hist_d = {hist_q[0], bit_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            pat_q     <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            hist_q    <= '0;
            idx_q     <= '0;
            acc_cnt_q <= '0;
            acc_map_q <= '0;
            done_id_q <= 1'b0;
            cnt_q     <= '0;
            map_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        word_q    <= win_d ? bus.data1 : bus.data0;
                        pat_q     <= bus.cfg_pattern;
                        id_q      <= win_d;
                        hist_q    <= '0;
                        acc_cnt_q <= '0;
                        acc_map_q <= '0;
                        idx_q     <= IDX_TOP;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hit_d) begin
                        acc_cnt_q        <= acc_cnt_q + 4'd1;
                        acc_map_q[idx_q] <= 1'b1;
                    end
                    hist_q <= hist_d;
                    if (idx_q == '0) state_q <= REPORT;
                    else             idx_q   <= idx_q - 1'b1;
                end
                REPORT: begin
                    cnt_q     <= acc_cnt_q;
                    map_q     <= acc_map_q;
                    done_id_q <= id_q;
                    last_id_q <= id_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_d;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == REPORT);
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = cnt_q;
    assign bus.match_map = map_q;
endmodule
